shr_seq_ift: RTL
================

SHR_SEQ_IFT -- requirements
Module: shr_seq_ift

Interface
REQ-001: Parameter WIDTH, default 4, data width of a and c.
REQ-002: Parameter TWIDTH, default 32, taint-label width of a_t, b_t and c_t.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: in_valid  input  1  operand set on a/a_t/b/b_t is valid.
REQ-006: in_ready  output  1  block accepts an operand set this cycle.
REQ-007: a  input  WIDTH  value to shift.
REQ-008: a_t  input  TWIDTH  taint label of a.
REQ-009: b  input  WIDTH  shift amount, unsigned.
REQ-010: b_t  input  TWIDTH  taint label of b.
REQ-011: out_valid  output  1  result on c/c_t is valid.
REQ-012: out_ready  input  1  downstream consumes result this cycle.
REQ-013: c  output  WIDTH  logical right-shift result.
REQ-014: c_t  output  TWIDTH  taint label of c.
REQ-015: busy  output  1  high in any state other than IDLE.

Function
REQ-016: The block SHALL implement a three-state FSM (IDLE, SHIFT, DONE) with IDLE as reset state.
REQ-017: in_ready SHALL be high only in IDLE; out_valid SHALL be high only in DONE.
REQ-018: Accept (IDLE, in_valid=1): the block SHALL load shift register with a, load the count with min(b, WIDTH), and load the taint register with a_t | b_t.
REQ-019: After accept, the FSM SHALL go to SHIFT if the loaded count is nonzero, otherwise to DONE.
REQ-020: Each SHIFT cycle SHALL shift the register right by one, zero-fill the MSB, and decrement the count; the FSM SHALL enter DONE on the cycle the count goes from 1 to 0.
REQ-021: Latency from the accept edge to out_valid high SHALL be min(b, WIDTH)+1 cycles.
REQ-022: Shift amounts b >= WIDTH SHALL yield c = 0 after WIDTH shift cycles.
REQ-023: In DONE, c and c_t SHALL stay stable until out_ready=1, at which point the FSM SHALL return to IDLE on that edge.
REQ-024: No new operand SHALL be accepted in SHIFT or DONE; in_valid there SHALL be ignored and the upstream SHALL hold its data.
REQ-025: c and c_t SHALL be driven from registers, never combinationally from inputs.
REQ-026: c_t SHALL equal the captured a_t | b_t, regardless of shift amount or data value.
REQ-027: With in_valid and out_ready both high in DONE, only the output handshake SHALL complete; the input is accepted in the following IDLE cycle at the earliest.

Reset
REQ-028: On rst_n low, the block SHALL immediately go to IDLE: out_valid=0, c=0, c_t=0, busy=0, count=0, in_ready=1.
REQ-029: Reset asserted during SHIFT or DONE SHALL discard the in-flight operation with no output handshake.
REQ-030: The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-031: Macro SHR_SEQ_TAINT_EN SHALL control taint tracking.
REQ-032: Defined: the taint register is present and c_t behaves per REQ-026.
REQ-033: Undefined: the taint register is removed; a_t and b_t are ignored; c_t is constant 0. Ports are unchanged.

Verification
REQ-034: a=4'b1011, b=2, a_t=0, b_t=0, out_ready=1 -> out_valid 3 cycles after accept; c=4'b0010; c_t=0.
REQ-035: a=4'b0110, b=0 -> out_valid 1 cycle after accept; c=4'b0110.
REQ-036: a=4'b1111, b=7 -> 4 SHIFT cycles; out_valid 5 cycles after accept; c=4'b0000.
REQ-037: a_t=32'h0000_0001, b_t=32'h0000_0100, b=1, with the macro defined -> c_t=32'h0000_0101. Without the macro -> c_t=0.
REQ-038: out_ready held low 5 cycles in DONE with in_valid=1 -> c and c_t held, in_ready=0, no second accept. out_ready=1 -> IDLE next edge, then accept.
REQ-039: rst_n pulsed low mid-SHIFT (a=4'b1000, b=3) -> out_valid=0, c=0, in_ready=1 immediately. A new accept of a=4'b1000, b=1 after release gives c=4'b0100.

Source files
------------

// File: rtl/shr_seq_ift.sv
// Sequential logical right shifter with taint-label propagation.
// Taint register present only when SHR_SEQ_TAINT_EN is defined.
module shr_seq_ift #(
  parameter int WIDTH  = 4,
  parameter int TWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [TWIDTH-1:0] a_t,
  input  logic [WIDTH-1:0]  b,
  input  logic [TWIDTH-1:0] b_t,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  c,
  output logic [TWIDTH-1:0] c_t,
  output logic              busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_ld;
  logic             accept;

  // Amounts at or beyond WIDTH saturate: WIDTH shifts already clear everything.
  assign cnt_ld = (32'(b) >= 32'(WIDTH)) ? CNT_MAX : CW'(b);
  assign accept = (state == IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = (b == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (1'b1)
      (state == IDLE): begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      (state == DONE): out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sr  <= a;
      cnt <= cnt_ld;
    end else if (state == SHIFT) begin
      sr  <= sr >> 1;
      cnt <= cnt - CW'(1);
    end
  end

  assign c = sr;

`ifdef SHR_SEQ_TAINT_EN
  logic [TWIDTH-1:0] taint;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      taint <= '0;
    else if (accept) taint <= a_t | b_t;
  end

  assign c_t = taint;
`else
  logic unused_t;
  assign unused_t = ^{a_t, b_t};
  assign c_t = '0;
`endif

endmodule
